// File: rtl/interp_seq_ctrl.sv
// Start/done sequencer for the HEVC subpixel interpolation datapath: row load, H pass, V pass, drain.
// Optional row-stall counter is built only when INTERP_SEQ_STALL_CNT_EN is defined.
module interp_seq_ctrl #(
  parameter int ROWS     = 15,
  parameter int H_CYCLES = 16,
  parameter int V_CYCLES = 32,
  parameter int FIR_LAT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        row_valid,
  output logic        row_ready,
  output logic        in_load,
  output logic [7:0]  sel,
  output logic        h_load,
  output logic        out_load,
  output logic        busy,
  output logic        done,
  output logic [15:0] stall_cnt
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PW = (FIR_LAT > 1) ? $clog2(FIR_LAT) : 1;
  localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
  localparam logic [PW-1:0] P_LAST = PW'(FIR_LAT - 1);
  localparam logic [7:0]    H_LAST = 8'(H_CYCLES - 1);
  localparam logic [7:0]    V_LAST = 8'(H_CYCLES + V_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, HFILT, VFILT, DRAIN} state_t;

  state_t              state, state_nxt;
  logic [RW-1:0]       row_cnt, row_cnt_nxt;
  logic [PW-1:0]       phase, phase_nxt;
  logic [7:0]          sel_nxt;
  logic                done_nxt, push_h, push_v, flush;
  logic [FIR_LAT-1:0]  h_line, h_line_nxt, v_line, v_line_nxt;

  assign row_ready = (state == LOAD);
  assign in_load   = row_ready & row_valid;
  // The tail of each tag line is itself a flop, so the enables come straight off registers.
  assign h_load    = h_line[FIR_LAT-1];
  assign out_load  = v_line[FIR_LAT-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      row_cnt <= '0;
      phase   <= '0;
      sel     <= '0;
      h_line  <= '0;
      v_line  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      row_cnt <= row_cnt_nxt;
      phase   <= phase_nxt;
      sel     <= sel_nxt;
      h_line  <= h_line_nxt;
      v_line  <= v_line_nxt;
      busy    <= (state_nxt != IDLE);
      done    <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    row_cnt_nxt = row_cnt;
    phase_nxt   = phase;
    sel_nxt     = sel;
    done_nxt    = 1'b0;
    push_h      = 1'b0;
    push_v      = 1'b0;
    flush       = 1'b0;
    h_line_nxt  = '0;
    v_line_nxt  = '0;

    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt   = LOAD;
          row_cnt_nxt = '0;
          phase_nxt   = '0;
        end
      end
      LOAD: begin
        if (row_valid) begin
          if (row_cnt == R_LAST) begin
            state_nxt = HFILT;
            sel_nxt   = '0;
          end else begin
            row_cnt_nxt = row_cnt + 1'b1;
          end
        end
      end
      HFILT: begin
        push_h  = 1'b1;
        sel_nxt = sel + 8'd1;
        if (sel == H_LAST) state_nxt = VFILT;
      end
      VFILT: begin
        push_v = 1'b1;
        if (sel == V_LAST) begin
          state_nxt = DRAIN;
          phase_nxt = '0;
        end else begin
          sel_nxt = sel + 8'd1;
        end
      end
      DRAIN: begin
        if (phase == P_LAST) begin
          state_nxt = IDLE;
          sel_nxt   = '0;
          done_nxt  = 1'b1;
        end else begin
          phase_nxt = phase + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (abort && (state != IDLE)) begin
      state_nxt = IDLE;
      sel_nxt   = '0;
      done_nxt  = 1'b0;
      push_h    = 1'b0;
      push_v    = 1'b0;
      flush     = 1'b1;
    end

    if (!flush) begin
      h_line_nxt[0] = push_h;
      v_line_nxt[0] = push_v;
      for (int i = 1; i < FIR_LAT; i++) begin
        h_line_nxt[i] = h_line[i-1];
        v_line_nxt[i] = v_line[i-1];
      end
    end
  end

`ifdef INTERP_SEQ_STALL_CNT_EN
  logic [15:0] stall_q;

  // Counts starved LOAD cycles; cleared by an accepted start and held once the block ends.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else if ((state == IDLE) && start && !abort) begin
      stall_q <= '0;
    end else if ((state == LOAD) && !row_valid && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_interp_seq_ctrl.sv
// Directed, table-driven bench for interp_seq_ctrl: default-parameter blocks with stalls,
// abort/reset/start corner sequences, and a tiny-parameter instance.
module tb_interp_seq_ctrl;

  logic        clk, rst;
  logic        start, abort, row_valid;
  logic        row_ready, in_load, h_load, out_load, busy, done;
  logic [7:0]  sel;
  logic [15:0] stall_cnt;

  logic        s_start, s_abort, s_row_valid;
  logic        s_row_ready, s_in_load, s_h_load, s_out_load, s_busy, s_done;
  logic [7:0]  s_sel;
  logic [15:0] s_stall_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int stall_at;
    int stall_len;
    int exp_done;
    int exp_stall;
  } vec_t;

  vec_t vecs[4];

  interp_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .row_valid(row_valid),
    .row_ready(row_ready), .in_load(in_load), .sel(sel), .h_load(h_load),
    .out_load(out_load), .busy(busy), .done(done), .stall_cnt(stall_cnt)
  );

  interp_seq_ctrl #(.ROWS(4), .H_CYCLES(1), .V_CYCLES(1), .FIR_LAT(1)) dut_small (
    .clk(clk), .rst(rst), .start(s_start), .abort(s_abort), .row_valid(s_row_valid),
    .row_ready(s_row_ready), .in_load(s_in_load), .sel(s_sel), .h_load(s_h_load),
    .out_load(s_out_load), .busy(s_busy), .done(s_done), .stall_cnt(s_stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input int cyc, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cyc %0d got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_stall_of(input int v);
`ifdef INTERP_SEQ_STALL_CNT_EN
    return v;
`else
    return 0;
`endif
  endfunction

  // One default-parameter block; s shifts every post-LOAD window by the number of stalled rows.
  task automatic apply_stimulus(input vec_t v);
    int s, in_cnt, h_cnt, o_cnt;
    logic rv;
    s = v.stall_len;
    in_cnt = 0; h_cnt = 0; o_cnt = 0;
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    for (int c = 1; c <= v.exp_done + 1; c++) begin
      rv = !((c >= v.stall_at) && (c < v.stall_at + v.stall_len));
      row_valid = rv;
      @(negedge clk);
      check_output("busy", c, busy, (c >= 1 && c <= 65 + s));
      if (c >= 16 + s && c <= 63 + s)      check_output("sel", c, sel, c - 16 - s);
      else if (c >= 64 + s && c <= 65 + s) check_output("sel", c, sel, 47);
      else                                 check_output("sel", c, sel, 0);
      check_output("h_load", c, h_load, (c >= 18 + s && c <= 33 + s));
      check_output("out_load", c, out_load, (c >= 34 + s && c <= 65 + s));
      check_output("done", c, done, (c == v.exp_done));
      check_output("row_ready", c, row_ready, (c <= 15 + s));
      check_output("in_load", c, in_load, (c <= 15 + s) && rv);
      in_cnt += int'(in_load);
      h_cnt  += int'(h_load);
      o_cnt  += int'(out_load);
      next_cycle();
    end
    row_valid = 1'b1;
    check_output("in_load_count", v.exp_done, in_cnt, 15);
    check_output("h_load_count", v.exp_done, h_cnt, 16);
    check_output("out_load_count", v.exp_done, o_cnt, 32);
    check_output("stall_cnt", v.exp_done, stall_cnt, exp_stall_of(v.exp_stall));
  endtask

  initial begin
    int done_cnt, done_cyc;

    vecs[0] = '{stall_at: 0,  stall_len: 0, exp_done: 66, exp_stall: 0};
    vecs[1] = '{stall_at: 5,  stall_len: 3, exp_done: 69, exp_stall: 3};
    vecs[2] = '{stall_at: 1,  stall_len: 1, exp_done: 67, exp_stall: 1};
    vecs[3] = '{stall_at: 14, stall_len: 2, exp_done: 68, exp_stall: 2};

    rst = 1'b0; start = 1'b0; abort = 1'b0; row_valid = 1'b1;
    s_start = 1'b0; s_abort = 1'b0; s_row_valid = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_output("rst_busy", 0, busy, 0);
    check_output("rst_sel", 0, sel, 0);
    check_output("rst_loads", 0, {row_ready, in_load, h_load, out_load, done}, 0);
    check_output("rst_stall", 0, stall_cnt, 0);
    check_output("rst_small_busy", 0, s_busy, 0);
    next_cycle();
    rst = 1'b1;
    next_cycle();

    for (int i = 0; i < 4; i++) apply_stimulus(vecs[i]);

    // Abort in VFILT at sel=30 (cycle 46), then a full block must still run cleanly.
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    for (int c = 1; c < 46; c++) next_cycle();
    @(negedge clk);
    check_output("abort_pre_sel", 46, sel, 30);
    check_output("abort_pre_out", 46, out_load, 1);
    next_cycle();
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check_output("abort_busy", 47, busy, 0);
    check_output("abort_sel", 47, sel, 0);
    check_output("abort_loads", 47, {row_ready, in_load, h_load, out_load}, 0);
    done_cnt = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      done_cnt += int'(done);
      next_cycle();
    end
    check_output("abort_no_done", 47, done_cnt, 0);
    apply_stimulus(vecs[0]);

    // Starts while busy are ignored; exactly one done at cycle 66.
    start = 1'b1;
    next_cycle();
    done_cnt = 0; done_cyc = -1;
    for (int c = 1; c <= 75; c++) begin
      start = (c == 20 || c == 40);
      @(negedge clk);
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (c == 70) check_output("busy_after_ignored_start", c, busy, 0);
      next_cycle();
    end
    start = 1'b0;
    check_output("busy_start_done_cnt", 0, done_cnt, 1);
    check_output("busy_start_done_cyc", 0, done_cyc, 66);

    // start and abort together in IDLE: abort wins.
    start = 1'b1; abort = 1'b1;
    next_cycle();
    start = 1'b0; abort = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check_output("start_abort_busy", c, busy, 0);
      check_output("start_abort_ready", c, row_ready, 0);
      next_cycle();
    end

    // Asynchronous reset at sel=10 of HFILT (cycle 26), applied between clock edges.
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    for (int c = 1; c < 26; c++) next_cycle();
    @(negedge clk);
    check_output("rst_pre_sel", 26, sel, 10);
    check_output("rst_pre_h", 26, h_load, 1);
    #2 rst = 1'b0;
    #1;
    check_output("rst_async_busy", 26, busy, 0);
    check_output("rst_async_sel", 26, sel, 0);
    check_output("rst_async_h", 26, h_load, 0);
    check_output("rst_async_misc", 26, {row_ready, in_load, out_load, done}, 0);
    check_output("rst_async_stall", 26, stall_cnt, 0);
    next_cycle();
    rst = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check_output("rst_idle_busy", c, busy, 0);
      check_output("rst_idle_ready", c, row_ready, 0);
      check_output("rst_idle_done", c, done, 0);
      next_cycle();
    end

    // Tiny parameters: LOAD 1..4, HFILT 5, VFILT 6, DRAIN 7, done at 8.
    s_start = 1'b1;
    next_cycle();
    s_start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      check_output("small_busy", c, s_busy, (c <= 7));
      check_output("small_sel", c, s_sel, (c == 6 || c == 7) ? 1 : 0);
      check_output("small_h_load", c, s_h_load, (c == 6));
      check_output("small_out_load", c, s_out_load, (c == 7));
      check_output("small_done", c, s_done, (c == 8));
      check_output("small_in_load", c, s_in_load, (c <= 4));
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
